// File: rtl/riscv_amo_fsm_if.sv
// Request, memory-port and result signals of the AMO read-modify-write sequencer.
interface riscv_amo_fsm_if #(
   parameter int unsigned XLEN = 64
);
   localparam int unsigned F5W = 5;

   logic            i_riscv_amo_valid;
   logic [F5W-1:0]  i_riscv_amo_funct5;
   logic            i_riscv_amo_word;
   logic [XLEN-1:0] i_riscv_amo_address;
   logic [XLEN-1:0] i_riscv_amo_rs2;
   logic [XLEN-1:0] i_riscv_amo_mem_rdata;
   logic            i_riscv_amo_mem_ready;

   logic [XLEN-1:0] o_riscv_amo_mem_addr;
   logic            o_riscv_amo_mem_read;
   logic            o_riscv_amo_mem_write;
   logic            o_riscv_amo_mem_word;
   logic [XLEN-1:0] o_riscv_amo_mem_wdata;
   logic            o_riscv_amo_stall;
   logic            o_riscv_amo_done;
   logic [XLEN-1:0] o_riscv_amo_rd_value;
   logic            o_riscv_amo_misaligned;
   logic            o_riscv_amo_kill_resv;

   // Pipeline / memory side: drives requests and memory responses.
   modport master (
      output i_riscv_amo_valid, i_riscv_amo_funct5, i_riscv_amo_word,
             i_riscv_amo_address, i_riscv_amo_rs2,
             i_riscv_amo_mem_rdata, i_riscv_amo_mem_ready,
      input  o_riscv_amo_mem_addr, o_riscv_amo_mem_read, o_riscv_amo_mem_write,
             o_riscv_amo_mem_word, o_riscv_amo_mem_wdata, o_riscv_amo_stall,
             o_riscv_amo_done, o_riscv_amo_rd_value, o_riscv_amo_misaligned,
             o_riscv_amo_kill_resv
   );

   // Sequencer side.
   modport slave (
      input  i_riscv_amo_valid, i_riscv_amo_funct5, i_riscv_amo_word,
             i_riscv_amo_address, i_riscv_amo_rs2,
             i_riscv_amo_mem_rdata, i_riscv_amo_mem_ready,
      output o_riscv_amo_mem_addr, o_riscv_amo_mem_read, o_riscv_amo_mem_write,
             o_riscv_amo_mem_word, o_riscv_amo_mem_wdata, o_riscv_amo_stall,
             o_riscv_amo_done, o_riscv_amo_rd_value, o_riscv_amo_misaligned,
             o_riscv_amo_kill_resv
   );
endinterface

// File: rtl/riscv_amo_fsm.sv
// RV64A AMO read-modify-write sequencer: stalls the memory stage, reads the old
// value, computes the new one, writes it back and returns the old value for rd.
module riscv_amo_fsm #(
   parameter int unsigned XLEN = 64
) (
   input  logic           i_riscv_amo_clk,
   input  logic           i_riscv_amo_rst,
   riscv_amo_fsm_if.slave amo_if
);

   localparam int unsigned HW  = 32;
   localparam int unsigned F5W = 5;
   localparam int unsigned SW  = 3;

   localparam logic [SW-1:0] S_IDLE  = 3'd0;
   localparam logic [SW-1:0] S_READ  = 3'd1;
   localparam logic [SW-1:0] S_CALC  = 3'd2;
   localparam logic [SW-1:0] S_WRITE = 3'd3;
   localparam logic [SW-1:0] S_DONE  = 3'd4;
   localparam logic [SW-1:0] S_FAULT = 3'd5;

   localparam logic [F5W-1:0] F_ADD  = 5'b00000;
   localparam logic [F5W-1:0] F_SWAP = 5'b00001;
   localparam logic [F5W-1:0] F_XOR  = 5'b00100;
   localparam logic [F5W-1:0] F_OR   = 5'b01000;
   localparam logic [F5W-1:0] F_AND  = 5'b01100;
   localparam logic [F5W-1:0] F_MIN  = 5'b10000;
   localparam logic [F5W-1:0] F_MAX  = 5'b10100;
   localparam logic [F5W-1:0] F_MINU = 5'b11000;
   localparam logic [F5W-1:0] F_MAXU = 5'b11100;

   logic [SW-1:0]   state_q, state_d;
   logic [F5W-1:0]  funct5_q;
   logic            word_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] rs2_q;
   logic [XLEN-1:0] old_q;
   logic [XLEN-1:0] new_q;
   logic [XLEN-1:0] rd_q;

   logic            legal_c;
   logic            misal_c;
   logic            accept_c;
   logic [XLEN-1:0] rdata_ext_c;
   logic [XLEN-1:0] new_c;
   logic [HW-1:0]   a_w, b_w, res_w;
   logic [XLEN-1:0] res_d;

   logic stall_c, read_c, write_c, done_c, mis_c, kill_c;

   // Decode which funct5 codes this unit owns and check natural alignment.
   always_comb begin
      legal_c = 1'b0;
      case (amo_if.i_riscv_amo_funct5)
         F_ADD, F_SWAP, F_XOR, F_OR, F_AND,
         F_MIN, F_MAX, F_MINU, F_MAXU: legal_c = 1'b1;
         default:                      legal_c = 1'b0;
      endcase
      misal_c  = amo_if.i_riscv_amo_word ? (amo_if.i_riscv_amo_address[1:0] != 2'b00)
                                         : (amo_if.i_riscv_amo_address[2:0] != 3'b000);
      accept_c = amo_if.i_riscv_amo_valid && legal_c;
   end

   // Old value as seen by rd: .W loads are sign-extended from bit 31.
   always_comb begin
      rdata_ext_c = amo_if.i_riscv_amo_mem_rdata;
      if (word_q) begin
         rdata_ext_c = {{(XLEN-HW){amo_if.i_riscv_amo_mem_rdata[HW-1]}},
                        amo_if.i_riscv_amo_mem_rdata[HW-1:0]};
      end
   end

   // New value from old and rs2; min/max keep old on a tie.
   always_comb begin
      a_w   = old_q[HW-1:0];
      b_w   = rs2_q[HW-1:0];
      res_w = a_w;
      res_d = old_q;
      case (funct5_q)
         F_SWAP: begin res_w = b_w;       res_d = rs2_q;         end
         F_ADD:  begin res_w = a_w + b_w; res_d = old_q + rs2_q; end
         F_XOR:  begin res_w = a_w ^ b_w; res_d = old_q ^ rs2_q; end
         F_AND:  begin res_w = a_w & b_w; res_d = old_q & rs2_q; end
         F_OR:   begin res_w = a_w | b_w; res_d = old_q | rs2_q; end
         F_MIN: begin
            res_w = ($signed(b_w) < $signed(a_w)) ? b_w : a_w;
            res_d = ($signed(rs2_q) < $signed(old_q)) ? rs2_q : old_q;
         end
         F_MAX: begin
            res_w = ($signed(a_w) < $signed(b_w)) ? b_w : a_w;
            res_d = ($signed(old_q) < $signed(rs2_q)) ? rs2_q : old_q;
         end
         F_MINU: begin
            res_w = (b_w < a_w) ? b_w : a_w;
            res_d = (rs2_q < old_q) ? rs2_q : old_q;
         end
         F_MAXU: begin
            res_w = (a_w < b_w) ? b_w : a_w;
            res_d = (old_q < rs2_q) ? rs2_q : old_q;
         end
         default: begin res_w = a_w; res_d = old_q; end
      endcase
      new_c = word_q ? {{(XLEN-HW){res_w[HW-1]}}, res_w} : res_d;
   end

   // State register.
   always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
      if (i_riscv_amo_rst) state_q <= S_IDLE;
      else                 state_q <= state_d;
   end

   // Next state and strobe decode; stall in IDLE reacts to the request directly.
   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      read_c  = 1'b0;
      write_c = 1'b0;
      done_c  = 1'b0;
      mis_c   = 1'b0;
      kill_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_c && !i_riscv_amo_rst) begin
               stall_c = 1'b1;
               state_d = misal_c ? S_FAULT : S_READ;
            end
         end
         S_READ: begin
            read_c  = 1'b1;
            stall_c = 1'b1;
            if (amo_if.i_riscv_amo_mem_ready) state_d = S_CALC;
         end
         S_CALC: begin
            stall_c = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            write_c = 1'b1;
            stall_c = 1'b1;
            if (amo_if.i_riscv_amo_mem_ready) begin
               kill_c  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_c  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAULT: begin
            mis_c   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture, old/new value registers and the held rd result.
   always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
      if (i_riscv_amo_rst) begin
         funct5_q <= '0;
         word_q   <= 1'b0;
         addr_q   <= '0;
         rs2_q    <= '0;
         old_q    <= '0;
         new_q    <= '0;
         rd_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  funct5_q <= amo_if.i_riscv_amo_funct5;
                  word_q   <= amo_if.i_riscv_amo_word;
                  addr_q   <= amo_if.i_riscv_amo_address;
                  rs2_q    <= amo_if.i_riscv_amo_rs2;
               end
            end
            S_READ:  if (amo_if.i_riscv_amo_mem_ready) old_q <= rdata_ext_c;
            S_CALC:  new_q <= new_c;
            S_WRITE: if (amo_if.i_riscv_amo_mem_ready) rd_q <= old_q;
            default: ;
         endcase
      end
   end

   assign amo_if.o_riscv_amo_mem_addr   = addr_q;
   assign amo_if.o_riscv_amo_mem_word   = word_q;
   assign amo_if.o_riscv_amo_mem_wdata  = new_q;
   assign amo_if.o_riscv_amo_rd_value   = rd_q;
   assign amo_if.o_riscv_amo_mem_read   = read_c;
   assign amo_if.o_riscv_amo_mem_write  = write_c;
   assign amo_if.o_riscv_amo_stall      = stall_c;
   assign amo_if.o_riscv_amo_done       = done_c;
   assign amo_if.o_riscv_amo_misaligned = mis_c;
   assign amo_if.o_riscv_amo_kill_resv  = kill_c;

endmodule

// File: tb/tb_riscv_amo_fsm.sv
// Bench for riscv_amo_fsm: directed AMO transactions against a behavioural model.
module tb_riscv_amo_fsm;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   logic clk = 1'b0;
   logic rst;

   riscv_amo_fsm_if #(.XLEN(64)) amo_if ();

   riscv_amo_fsm #(.XLEN(64)) dut (
      .i_riscv_amo_clk (clk),
      .i_riscv_amo_rst (rst),
      .amo_if          (amo_if)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Expected outputs for the current cycle.
   logic        check_en = 1'b0;
   logic        e_stall, e_read, e_write, e_done, e_mis, e_kill;
   logic        e_achk, e_wchk, e_word;
   logic [63:0] e_addr, e_wdata, e_rd;
   logic [63:0] model_rd;
   int          txn_cyc;

   // Observations taken from the DUT, compared with hand-computed literals.
   int          obs_done_cyc, obs_kill_cyc, obs_mis_cyc;
   logic [63:0] obs_wdata, obs_rd;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Spec-level result of an AMO: old value for rd and value stored to memory.
   function automatic void model(input logic [4:0] f, input logic w, input logic [63:0] mem,
                                 input logic [63:0] rs2, output logic [63:0] old_v,
                                 output logic [63:0] new_v);
      int                a, b;
      int unsigned       ua, ub;
      longint            sa, sb;
      longint unsigned   la, lb;
      logic [31:0]       r32;
      logic [63:0]       r64;
      a = mem[31:0];  b = rs2[31:0];
      ua = mem[31:0]; ub = rs2[31:0];
      sa = mem;       sb = rs2;
      la = mem;       lb = rs2;
      r32 = '0; r64 = '0;
      case (f)
         F_SWAP: begin r32 = b;                    r64 = lb;                    end
         F_ADD:  begin r32 = a + b;                r64 = la + lb;               end
         F_XOR:  begin r32 = a ^ b;                r64 = la ^ lb;               end
         F_AND:  begin r32 = a & b;                r64 = la & lb;               end
         F_OR:   begin r32 = a | b;                r64 = la | lb;               end
         F_MIN:  begin r32 = (a <= b) ? a : b;     r64 = (sa <= sb) ? sa : sb;  end
         F_MAX:  begin r32 = (a >= b) ? a : b;     r64 = (sa >= sb) ? sa : sb;  end
         F_MINU: begin r32 = (ua <= ub) ? ua : ub; r64 = (la <= lb) ? la : lb;  end
         F_MAXU: begin r32 = (ua >= ub) ? ua : ub; r64 = (la >= lb) ? la : lb;  end
         default: ;
      endcase
      if (w) begin
         old_v = {{32{mem[31]}}, mem[31:0]};
         new_v = {32'h0, r32};
      end else begin
         old_v = mem;
         new_v = r64;
      end
   endfunction

   task automatic idle_exp();
      e_stall = 1'b0; e_read = 1'b0; e_write = 1'b0;
      e_done  = 1'b0; e_mis  = 1'b0; e_kill  = 1'b0;
      e_achk  = 1'b0; e_wchk = 1'b0;
      e_rd    = model_rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      txn_cyc++;
   endtask

   // Per-cycle comparison of every output against the expectations.
   always @(negedge clk) begin
      if (check_en) begin
         check("stall",      64'(amo_if.o_riscv_amo_stall),      64'(e_stall));
         check("mem_read",   64'(amo_if.o_riscv_amo_mem_read),   64'(e_read));
         check("mem_write",  64'(amo_if.o_riscv_amo_mem_write),  64'(e_write));
         check("done",       64'(amo_if.o_riscv_amo_done),       64'(e_done));
         check("misaligned", 64'(amo_if.o_riscv_amo_misaligned), 64'(e_mis));
         check("kill_resv",  64'(amo_if.o_riscv_amo_kill_resv),  64'(e_kill));
         check("rd_value",   amo_if.o_riscv_amo_rd_value,        e_rd);
         if (e_achk) begin
            check("mem_addr", amo_if.o_riscv_amo_mem_addr,       e_addr);
            check("mem_word", 64'(amo_if.o_riscv_amo_mem_word),  64'(e_word));
         end
         if (e_wchk) begin
            check("mem_wdata",
                  e_word ? {32'h0, amo_if.o_riscv_amo_mem_wdata[31:0]} : amo_if.o_riscv_amo_mem_wdata,
                  e_wdata);
         end
      end
      if (amo_if.o_riscv_amo_done) begin
         obs_done_cyc = txn_cyc;
         obs_rd       = amo_if.o_riscv_amo_rd_value;
      end
      if (amo_if.o_riscv_amo_kill_resv) begin
         obs_kill_cyc = txn_cyc;
         obs_wdata    = amo_if.o_riscv_amo_mem_wdata;
      end
      if (amo_if.o_riscv_amo_misaligned) obs_mis_cyc = txn_cyc;
   end

   task automatic drive_req(input logic [4:0] f, input logic w, input logic [63:0] addr,
                            input logic [63:0] rs2, input logic [63:0] mem);
      amo_if.i_riscv_amo_valid     = 1'b1;
      amo_if.i_riscv_amo_funct5    = f;
      amo_if.i_riscv_amo_word      = w;
      amo_if.i_riscv_amo_address   = addr;
      amo_if.i_riscv_amo_rs2       = rs2;
      amo_if.i_riscv_amo_mem_rdata = mem;
      amo_if.i_riscv_amo_mem_ready = 1'b0;
   endtask

   // One complete request: rw / ww ready-low cycles in READ / WRITE.
   task automatic run_amo(input logic [4:0] f, input logic w, input logic [63:0] addr,
                          input logic [63:0] rs2, input logic [63:0] mem,
                          input int rw, input int ww);
      logic [63:0] m_old, m_new;
      logic        legal, mis;
      model(f, w, mem, rs2, m_old, m_new);
      legal = f inside {F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU};
      mis   = w ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000);
      obs_done_cyc = -1; obs_kill_cyc = -1; obs_mis_cyc = -1;
      obs_wdata = '0; obs_rd = '0;

      step();
      txn_cyc = 0;
      drive_req(f, w, addr, rs2, mem);
      idle_exp();
      e_stall = legal;
      if (!legal) begin
         step();
         step();
         amo_if.i_riscv_amo_valid = 1'b0;
         return;
      end
      if (mis) begin
         step();
         e_stall = 1'b0;
         e_mis   = 1'b1;
         step();
         amo_if.i_riscv_amo_valid = 1'b0;
         idle_exp();
         return;
      end
      e_addr = addr;
      e_word = w;
      for (int i = 0; i <= rw; i++) begin
         step();
         amo_if.i_riscv_amo_mem_ready = (i == rw);
         e_stall = 1'b1; e_read = 1'b1; e_achk = 1'b1;
      end
      step();
      amo_if.i_riscv_amo_mem_ready = 1'b0;
      e_read = 1'b0;
      for (int j = 0; j <= ww; j++) begin
         step();
         amo_if.i_riscv_amo_mem_ready = (j == ww);
         e_write = 1'b1; e_wchk = 1'b1; e_wdata = m_new;
         e_kill  = (j == ww);
      end
      step();
      amo_if.i_riscv_amo_mem_ready = 1'b0;
      model_rd = m_old;
      idle_exp();
      e_done = 1'b1;
      step();
      amo_if.i_riscv_amo_valid = 1'b0;
      idle_exp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      model_rd = '0;
      txn_cyc  = 0;
      amo_if.i_riscv_amo_valid     = 1'b0;
      amo_if.i_riscv_amo_funct5    = '0;
      amo_if.i_riscv_amo_word      = 1'b0;
      amo_if.i_riscv_amo_address   = '0;
      amo_if.i_riscv_amo_rs2       = '0;
      amo_if.i_riscv_amo_mem_rdata = '0;
      amo_if.i_riscv_amo_mem_ready = 1'b0;
      idle_exp();

      // Reset state.
      #2;
      check("rst_stall",    64'(amo_if.o_riscv_amo_stall),      64'h0);
      check("rst_read",     64'(amo_if.o_riscv_amo_mem_read),   64'h0);
      check("rst_write",    64'(amo_if.o_riscv_amo_mem_write),  64'h0);
      check("rst_done",     64'(amo_if.o_riscv_amo_done),       64'h0);
      check("rst_mis",      64'(amo_if.o_riscv_amo_misaligned), 64'h0);
      check("rst_kill",     64'(amo_if.o_riscv_amo_kill_resv),  64'h0);
      check("rst_rd",       amo_if.o_riscv_amo_rd_value,        64'h0);
      check("rst_addr",     amo_if.o_riscv_amo_mem_addr,        64'h0);
      check("rst_wdata",    amo_if.o_riscv_amo_mem_wdata,       64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_en = 1'b1;

      // AMOADD.D overflow into the sign bit, no wait states.
      run_amo(F_ADD, 1'b0, 64'h1000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
      check("lit_add_wdata", obs_wdata,             64'h8000_0000_0000_0000);
      check("lit_add_rd",    obs_rd,                64'h7FFF_FFFF_FFFF_FFFF);
      check("lit_add_done",  64'(obs_done_cyc),     64'd4);
      check("lit_add_kill",  64'(obs_kill_cyc),     64'd3);

      // AMOMIN.W vs AMOMINU.W; upper rdata bits are garbage.
      run_amo(F_MIN, 1'b1, 64'h2004, 64'h5, 64'hDEAD_BEEF_FFFF_FFFE, 0, 0);
      check("lit_minw_wdata", {32'h0, obs_wdata[31:0]}, 64'hFFFF_FFFE);
      check("lit_minw_rd",    obs_rd,                   64'hFFFF_FFFF_FFFF_FFFE);
      run_amo(F_MINU, 1'b1, 64'h2004, 64'h5, 64'hDEAD_BEEF_FFFF_FFFE, 0, 0);
      check("lit_minuw_wdata", {32'h0, obs_wdata[31:0]}, 64'h5);

      // AMOSWAP.D with wait states in READ and WRITE.
      run_amo(F_SWAP, 1'b0, 64'h3008, 64'hA5A5_5A5A_0123_4567, 64'h1111_2222_3333_4444, 3, 2);
      check("lit_swap_wdata", obs_wdata,         64'hA5A5_5A5A_0123_4567);
      check("lit_swap_done",  64'(obs_done_cyc), 64'd9);
      check("lit_swap_rd",    obs_rd,            64'h1111_2222_3333_4444);

      // Misaligned AMOOR.W and AMOADD.D.
      run_amo(F_OR, 1'b1, 64'h1002, 64'h1, 64'h0, 0, 0);
      check("lit_mis_cyc", 64'(obs_mis_cyc), 64'd1);
      run_amo(F_ADD, 1'b0, 64'h1004, 64'h1, 64'h0, 0, 0);

      // LR / SC codes are not taken by this unit.
      run_amo(F_LR, 1'b0, 64'h1000, 64'h0, 64'h0, 0, 0);
      run_amo(F_SC, 1'b1, 64'h1000, 64'h0, 64'h0, 0, 0);

      // Further operations, signed/unsigned and tie cases.
      run_amo(F_MAX,  1'b0, 64'h2000, 64'h5, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
      run_amo(F_MAXU, 1'b0, 64'h2000, 64'h5, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1);
      run_amo(F_AND,  1'b1, 64'h6004, 64'h0FF0_0FF0, 64'h1234_5678_F0F0_F0F0, 1, 0);
      check("lit_andw_rd", obs_rd, 64'hFFFF_FFFF_F0F0_F0F0);
      run_amo(F_ADD,  1'b1, 64'h6000, 64'h1, 64'h0000_0000_FFFF_FFFF, 1, 1);
      check("lit_addw_wrap", {32'h0, obs_wdata[31:0]}, 64'h0);
      run_amo(F_MAX,  1'b1, 64'h600C, 64'h8000_0000, 64'h8000_0000, 0, 0);
      run_amo(F_MINU, 1'b0, 64'h7010, 64'h10, 64'h20, 2, 0);
      run_amo(F_XOR,  1'b1, 64'h7014, 64'hFFFF_0000, 64'h0F0F_0F0F, 0, 0);

      // Reset in WRITE with memory not ready.
      step();
      txn_cyc = 0;
      drive_req(F_SWAP, 1'b0, 64'h4000, 64'h55, 64'h33);
      idle_exp(); e_stall = 1'b1;
      step();
      amo_if.i_riscv_amo_mem_ready = 1'b1;
      e_read = 1'b1; e_achk = 1'b1; e_addr = 64'h4000; e_word = 1'b0;
      step();
      amo_if.i_riscv_amo_mem_ready = 1'b0;
      e_read = 1'b0;
      step();
      e_write = 1'b1; e_wchk = 1'b1; e_wdata = 64'h55;
      step();
      check_en = 1'b0;
      #1;
      check("pre_rst_write", 64'(amo_if.o_riscv_amo_mem_write), 64'h1);
      rst = 1'b1;
      #1;
      check("rst_mid_write", 64'(amo_if.o_riscv_amo_mem_write), 64'h0);
      check("rst_mid_stall", 64'(amo_if.o_riscv_amo_stall),     64'h0);
      check("rst_mid_kill",  64'(amo_if.o_riscv_amo_kill_resv), 64'h0);
      check("rst_mid_read",  64'(amo_if.o_riscv_amo_mem_read),  64'h0);
      model_rd = '0;
      step();
      amo_if.i_riscv_amo_valid = 1'b0;
      check("rst_mid_addr", amo_if.o_riscv_amo_mem_addr,  64'h0);
      check("rst_mid_rd",   amo_if.o_riscv_amo_rd_value,  64'h0);
      step();
      rst = 1'b0;
      idle_exp();
      check_en = 1'b1;

      // Fresh AMOXOR.D after reset release.
      run_amo(F_XOR, 1'b0, 64'h5000, 64'hFF, 64'hF0, 0, 0);
      check("lit_xor_wdata", obs_wdata, 64'h0F);
      check("lit_xor_rd",    obs_rd,    64'hF0);

      step();
      step();
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
